imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Sequencer and arbiter for the fetch-stage instruction memory write port. After reset it holds the core in reset and streams a program image into instruction memory over a valid/ready port. It then releases the core and gates the fetch pipeline register (EN/CLR). While running, it arbitrates single-word debug writes against fetch by stalling and flushing the IF/ID register around each write.

## Interface

Parameters:
- width, 32, instruction/data word width
- ADDR_W, 8, instruction memory word-address width (depth 2^ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- ld_start  in  1  single-cycle pulse; begin or restart an image load
- ld_valid  in  1  load word valid
- ld_data  in  width  load word
- ld_last  in  1  qualifies the final word of the image
- ld_ready  out  1  load word accepted when ld_valid && ld_ready
- dbg_wr_req  in  1  debug write request; level, held until dbg_wr_ack
- dbg_addr  in  ADDR_W  debug write word address
- dbg_data  in  width  debug write data
- dbg_wr_ack  out  1  one-cycle pulse when the debug write is performed
- hazard_stall  in  1  fetch stall from the hazard unit
- fetch_en  out  1  to fetch EN; IF/ID register update enable
- fetch_clr  out  1  to fetch CLR; IF/ID register flush
- core_rst_n  out  1  active-low reset to the rest of the core
- mem_we  out  1  instruction memory write enable
- mem_waddr  out  ADDR_W  instruction memory write word address
- mem_wdata  out  width  instruction memory write data
- word_count  out  ADDR_W+1  number of words accepted in the current/last load
- load_done  out  1  image loaded and core released
- overflow  out  1  image exceeded memory depth

## Operation

- States: IDLE, LOAD, FLUSH, RUN, DBG, ERR. Reset enters IDLE.
- IDLE: core_rst_n=0. ld_start moves to LOAD. dbg_wr_req is ignored and never acked.
- LOAD:
  - ld_ready=1 and core_rst_n=0.
  - Each accepted word produces a registered write: in the following cycle mem_we=1, mem_waddr=word_count (pre-increment), mem_wdata=ld_data. word_count then increments.
  - Accepting a word with ld_last=1 moves to FLUSH.
  - Accepting the word at address 2^ADDR_W-1 with ld_last=0 writes that word, sets overflow, and moves to ERR.
- ERR: ld_ready=0, core_rst_n=0, overflow=1. Only ld_start or rst_n leaves this state.
- ld_start in any state:
  - clears word_count, load_done and overflow;
  - drives core_rst_n=0 from the next cycle;
  - moves to LOAD.
  - It has priority over any same-cycle handshake or dbg_wr_req; that handshake word and that request are dropped and not acked.
- FLUSH: lasts one cycle, then RUN.
  - fetch_clr=1, fetch_en=0.
  - core_rst_n=1 if entered from DBG; if entered from LOAD, core_rst_n stays 0 in FLUSH and rises on entry to RUN.
  - load_done is set on FLUSH→RUN when coming from LOAD.
- RUN:
  - core_rst_n=1, ld_ready=0.
  - fetch_en = !hazard_stall (combinational on state and hazard_stall).
  - dbg_wr_req=1 captures dbg_addr/dbg_data and moves to DBG.
- DBG: lasts one cycle, then FLUSH.
  - fetch_en=0, mem_we=1 with the captured address/data, dbg_wr_ack=1.
- mem_we=0 in all cycles other than those listed above.
- word_count saturates at 2^ADDR_W and never wraps.

## Timing

- Reset values (asynchronous): state IDLE; fetch_en=0, fetch_clr=0, core_rst_n=0, mem_we=0, mem_waddr=0, mem_wdata=0, ld_ready=0, dbg_wr_ack=0, word_count=0, load_done=0, overflow=0.
- Reset mid-load or mid-debug-write aborts immediately. No further mem_we is issued.
- Registered outputs: core_rst_n, fetch_clr, mem_*, dbg_wr_ack, word_count, load_done, overflow.
- Combinational outputs (from state only, or state plus hazard_stall): fetch_en, ld_ready.
- Load throughput: one word per cycle. Write latency: 1 cycle after handshake.
- Last word to core release: handshake cycle N; write in N+1 (FLUSH); RUN with core_rst_n=1 in N+2.
- Debug write: request sampled in RUN cycle T; DBG (write, ack) in T+1; FLUSH in T+2; RUN in T+3. Fetch is frozen for 2 cycles.
- hazard_stall in DBG/FLUSH has no extra effect.

## Test plan

- Reset, ld_start, 4 words 0x11..0x44 with ld_last on the 4th, back-to-back → writes to addresses 0..3 one cycle after each handshake; word_count=4; core_rst_n rises 2 cycles after the last handshake; load_done=1.
- ADDR_W=2, 5-word image with no ld_last → addresses 0..3 written; overflow=1; ERR with ld_ready=0. ld_start then clears overflow and word_count=0.
- RUN, dbg_wr_req with addr 0x05 / data 0xDEADBEEF → mem_we at T+1 with dbg_wr_ack pulse; fetch_en=0 at T+1 and T+2; fetch_clr=1 at T+2; fetch_en restored at T+3.
- RUN with hazard_stall toggled → fetch_en is its inverse in the same cycle; no memory writes.
- ld_start and dbg_wr_req asserted together in RUN → LOAD entered; no dbg_wr_ack; core_rst_n=0 next cycle.
- rst_n asserted mid-load after 2 words → all outputs at reset values immediately; no further mem_we.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// Purpose : bundles the image-load stream, the debug write port and the
//           instruction-memory write port of imem_load_ctrl.
// Ports   : master = load/debug source and memory sink; slave = the controller.
interface imem_load_ctrl_if #(
  parameter int width  = 32,
  parameter int ADDR_W = 8
);
  // image load stream (valid/ready)
  logic              ld_start;
  logic              ld_valid;
  logic [width-1:0]  ld_data;
  logic              ld_last;
  logic              ld_ready;
  // debug single-word write
  logic              dbg_wr_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [width-1:0]  dbg_data;
  logic              dbg_wr_ack;
  // instruction memory write port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [width-1:0]  mem_wdata;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    output dbg_wr_req, dbg_addr, dbg_data,
    input  ld_ready, dbg_wr_ack,
    input  mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  dbg_wr_req, dbg_addr, dbg_data,
    output ld_ready, dbg_wr_ack,
    output mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Purpose : loads a program image into instruction memory with the core held
//           in reset, then releases the core and arbitrates debug writes
//           against fetch by freezing and flushing the IF/ID register.
// Ports   : clk/rst_n; bus (load stream, debug write, memory write port);
//           hazard_stall in; fetch_en/fetch_clr/core_rst_n to the core;
//           word_count/load_done/overflow status.
// Latency : memory write one cycle after the load handshake or debug request;
//           ld_ready and fetch_en are combinational, all else registered.
module imem_load_ctrl #(
  parameter int width  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_load_ctrl_if.slave   bus,
  input  logic              hazard_stall,
  output logic              fetch_en,
  output logic              fetch_clr,
  output logic              core_rst_n,
  output logic [ADDR_W:0]   word_count,
  output logic              load_done,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DBG, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_ADDR = DEPTH - (ADDR_W+1)'(1);

  state_t state, state_nxt;
  // remembers whether the current FLUSH follows an image load (core release)
  // or a debug write (core already running)
  logic from_load, from_load_nxt;

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [width-1:0]  mem_wdata_q, mem_wdata_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              fetch_clr_d, core_rst_n_d, load_done_d, overflow_d;
  logic [ADDR_W:0]   word_count_d;

  // ld_start wins over any same-cycle handshake or debug request
  logic ld_acc, dbg_go, at_top;
  assign ld_acc = (state == LOAD) && bus.ld_valid && !bus.ld_start;
  assign dbg_go = (state == RUN) && bus.dbg_wr_req && !bus.ld_start;
  assign at_top = (word_count == LAST_ADDR);

  // state register (plus the registered outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      from_load   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      fetch_clr   <= 1'b0;
      core_rst_n  <= 1'b0;
      word_count  <= '0;
      load_done   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      from_load   <= from_load_nxt;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      dbg_ack_q   <= dbg_ack_d;
      fetch_clr   <= fetch_clr_d;
      core_rst_n  <= core_rst_n_d;
      word_count  <= word_count_d;
      load_done   <= load_done_d;
      overflow    <= overflow_d;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt     = state;
    from_load_nxt = from_load;
    if (bus.ld_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (ld_acc) begin
            if (bus.ld_last) begin
              state_nxt     = FLUSH;
              from_load_nxt = 1'b1;
            end else if (at_top) begin
              state_nxt = ERR;
            end
          end
        end
        FLUSH: state_nxt = RUN;
        RUN:   if (dbg_go) state_nxt = DBG;
        DBG: begin
          state_nxt     = FLUSH;
          from_load_nxt = 1'b0;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // output logic: next values of the registered outputs
  always_comb begin
    mem_we_d    = ld_acc || dbg_go;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (ld_acc) begin
      mem_waddr_d = word_count[ADDR_W-1:0];
      mem_wdata_d = bus.ld_data;
    end else if (dbg_go) begin
      mem_waddr_d = bus.dbg_addr;
      mem_wdata_d = bus.dbg_data;
    end
    dbg_ack_d   = dbg_go;
    fetch_clr_d = (state_nxt == FLUSH);
    // after a load the core stays in reset through FLUSH; after a debug
    // write it never leaves the running domain
    core_rst_n_d = (state_nxt == RUN) || (state_nxt == DBG) ||
                   ((state_nxt == FLUSH) && (state == DBG));
    word_count_d = word_count;
    load_done_d  = load_done;
    overflow_d   = overflow;
    if (bus.ld_start) begin
      word_count_d = '0;
      load_done_d  = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (ld_acc && (word_count != DEPTH))
        word_count_d = word_count + (ADDR_W+1)'(1);
      if (ld_acc && !bus.ld_last && at_top)
        overflow_d = 1'b1;
      if ((state == FLUSH) && from_load)
        load_done_d = 1'b1;
    end
  end

  assign bus.ld_ready   = (state == LOAD);
  assign fetch_en       = (state == RUN) && !hazard_stall;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dbg_wr_ack = dbg_ack_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Purpose : self-checking bench for imem_load_ctrl; two instances (8-bit and
//           2-bit address) share one stimulus stream and are compared each
//           cycle against a behavioural model of the load/run/debug rules.
module tb_imem_load_ctrl;
  localparam int W   = 32;
  localparam int AW0 = 8;
  localparam int AW1 = 2;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_RUN   = 3;
  localparam int M_DBG   = 4;
  localparam int M_ERR   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic          s_start = 0, s_vld = 0, s_last = 0, s_dreq = 0, hz = 0;
  logic [W-1:0]  s_data = '0, s_ddata = '0;
  logic [7:0]    s_daddr = '0;

  imem_load_ctrl_if #(.width(W), .ADDR_W(AW0)) bus0 ();
  imem_load_ctrl_if #(.width(W), .ADDR_W(AW1)) bus1 ();

  assign bus0.ld_start = s_start;   assign bus1.ld_start = s_start;
  assign bus0.ld_valid = s_vld;     assign bus1.ld_valid = s_vld;
  assign bus0.ld_data  = s_data;    assign bus1.ld_data  = s_data;
  assign bus0.ld_last  = s_last;    assign bus1.ld_last  = s_last;
  assign bus0.dbg_wr_req = s_dreq;  assign bus1.dbg_wr_req = s_dreq;
  assign bus0.dbg_addr = s_daddr;   assign bus1.dbg_addr = s_daddr[AW1-1:0];
  assign bus0.dbg_data = s_ddata;   assign bus1.dbg_data = s_ddata;

  logic fen0, fclr0, crst0, done0, ovf0;
  logic fen1, fclr1, crst1, done1, ovf1;
  logic [AW0:0] cnt0;
  logic [AW1:0] cnt1;

  imem_load_ctrl #(.width(W), .ADDR_W(AW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .hazard_stall(hz),
    .fetch_en(fen0), .fetch_clr(fclr0), .core_rst_n(crst0),
    .word_count(cnt0), .load_done(done0), .overflow(ovf0));

  imem_load_ctrl #(.width(W), .ADDR_W(AW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .hazard_stall(hz),
    .fetch_en(fen1), .fetch_clr(fclr1), .core_rst_n(crst1),
    .word_count(cnt1), .load_done(done1), .overflow(ovf1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // observed outputs, per instance
  logic         o_rdy[2], o_fen[2], o_clr[2], o_core[2], o_we[2], o_ack[2], o_done[2], o_ovf[2];
  int           o_cnt[2], o_waddr[2];
  logic [W-1:0] o_wdata[2];

  task automatic sample_outputs();
    o_rdy[0] = bus0.ld_ready;   o_rdy[1] = bus1.ld_ready;
    o_fen[0] = fen0;            o_fen[1] = fen1;
    o_clr[0] = fclr0;           o_clr[1] = fclr1;
    o_core[0] = crst0;          o_core[1] = crst1;
    o_we[0] = bus0.mem_we;      o_we[1] = bus1.mem_we;
    o_ack[0] = bus0.dbg_wr_ack; o_ack[1] = bus1.dbg_wr_ack;
    o_done[0] = done0;          o_done[1] = done1;
    o_ovf[0] = ovf0;            o_ovf[1] = ovf1;
    o_cnt[0] = int'(cnt0);      o_cnt[1] = int'(cnt1);
    o_waddr[0] = int'(bus0.mem_waddr); o_waddr[1] = int'(bus1.mem_waddr);
    o_wdata[0] = bus0.mem_wdata; o_wdata[1] = bus1.mem_wdata;
  endtask

  // reference model: operating mode plus expected registered outputs
  int           depth[2] = '{256, 4};
  int           m_mode[2];
  bit           m_from_load[2];
  bit           e_core[2], e_clr[2], e_we[2], e_ack[2], e_done[2], e_ovf[2];
  int           e_cnt[2], e_waddr[2];
  logic [W-1:0] e_wdata[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_from_load[k] = 0;
      e_core[k] = 0; e_clr[k] = 0; e_we[k] = 0; e_ack[k] = 0;
      e_done[k] = 0; e_ovf[k] = 0; e_cnt[k] = 0; e_waddr[k] = 0; e_wdata[k] = '0;
    end
  endtask

  // advance the model across one rising edge using the current inputs
  task automatic m_step();
    bit was_top;
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 0; e_ack[k] = 0; e_clr[k] = 0;
      if (s_start) begin
        m_mode[k] = M_LOAD; e_cnt[k] = 0; e_done[k] = 0; e_ovf[k] = 0; e_core[k] = 0;
      end else if (m_mode[k] == M_LOAD) begin
        if (s_vld) begin
          e_we[k] = 1; e_waddr[k] = e_cnt[k]; e_wdata[k] = s_data;
          was_top = (e_cnt[k] == depth[k] - 1);
          if (e_cnt[k] < depth[k]) e_cnt[k]++;
          if (s_last) begin
            m_mode[k] = M_FLUSH; m_from_load[k] = 1; e_clr[k] = 1;
          end else if (was_top) begin
            m_mode[k] = M_ERR; e_ovf[k] = 1;
          end
        end
      end else if (m_mode[k] == M_FLUSH) begin
        m_mode[k] = M_RUN; e_core[k] = 1;
        if (m_from_load[k]) e_done[k] = 1;
      end else if (m_mode[k] == M_RUN) begin
        if (s_dreq) begin
          m_mode[k] = M_DBG; e_we[k] = 1; e_ack[k] = 1;
          e_waddr[k] = int'(s_daddr) % depth[k]; e_wdata[k] = s_ddata;
        end
      end else if (m_mode[k] == M_DBG) begin
        m_mode[k] = M_FLUSH; m_from_load[k] = 0; e_clr[k] = 1; e_core[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    sample_outputs();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ld_ready%0d", k), o_rdy[k], m_mode[k] == M_LOAD);
      check_val($sformatf("fetch_en%0d", k), o_fen[k], (m_mode[k] == M_RUN) && !hz);
      check_val($sformatf("fetch_clr%0d", k), o_clr[k], e_clr[k]);
      check_val($sformatf("core_rst_n%0d", k), o_core[k], e_core[k]);
      check_val($sformatf("mem_we%0d", k), o_we[k], e_we[k]);
      check_val($sformatf("dbg_wr_ack%0d", k), o_ack[k], e_ack[k]);
      check_val($sformatf("word_count%0d", k), o_cnt[k], e_cnt[k]);
      check_val($sformatf("load_done%0d", k), o_done[k], e_done[k]);
      check_val($sformatf("overflow%0d", k), o_ovf[k], e_ovf[k]);
      if (e_we[k]) begin
        check_val($sformatf("mem_waddr%0d", k), o_waddr[k], e_waddr[k]);
        check_val($sformatf("mem_wdata%0d", k), o_wdata[k], e_wdata[k]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    sample_outputs();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s_ld_ready%0d", tag, k), o_rdy[k], 0);
      check_val($sformatf("%s_fetch_en%0d", tag, k), o_fen[k], 0);
      check_val($sformatf("%s_fetch_clr%0d", tag, k), o_clr[k], 0);
      check_val($sformatf("%s_core_rst_n%0d", tag, k), o_core[k], 0);
      check_val($sformatf("%s_mem_we%0d", tag, k), o_we[k], 0);
      check_val($sformatf("%s_mem_waddr%0d", tag, k), o_waddr[k], 0);
      check_val($sformatf("%s_mem_wdata%0d", tag, k), o_wdata[k], 0);
      check_val($sformatf("%s_dbg_wr_ack%0d", tag, k), o_ack[k], 0);
      check_val($sformatf("%s_word_count%0d", tag, k), o_cnt[k], 0);
      check_val($sformatf("%s_load_done%0d", tag, k), o_done[k], 0);
      check_val($sformatf("%s_overflow%0d", tag, k), o_ovf[k], 0);
    end
  endtask

  // one clock cycle: drive at the falling edge, check, then step the model
  task automatic cycle(input bit st, input bit vld, input logic [W-1:0] data, input bit last,
                       input bit dreq, input logic [7:0] daddr, input logic [W-1:0] ddata,
                       input bit h);
    @(negedge clk);
    s_start = st; s_vld = vld; s_data = data; s_last = last;
    s_dreq = dreq; s_daddr = daddr; s_ddata = ddata; hz = h;
    #1;
    compare_all();
    m_step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    m_reset();
    @(negedge clk); #1;
    check_reset("por");
    rst_n = 1'b1;

    // 4-word image 0x11..0x44, back-to-back, last on the 4th
    cycle(1, 0, '0, 0, 0, '0, '0, 0);
    for (int i = 1; i <= 4; i++)
      cycle(0, 1, W'(i * 'h11), i == 4, 0, '0, '0, 0);
    idle_cycles(3);

    // debug write while running; request held until acked
    cycle(0, 0, '0, 0, 1, 8'h05, 32'hDEADBEEF, 0);
    cycle(0, 0, '0, 0, 1, 8'h05, 32'hDEADBEEF, 0);
    idle_cycles(3);

    // hazard stall toggling in RUN
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0, 0, '0, '0, i[0]);

    // ld_start together with a debug request: load wins, no ack
    cycle(1, 0, '0, 0, 1, 8'h07, 32'h12345678, 0);
    // 5 words without last: the 2-bit instance overflows into ERR
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, 0, 0, '0, '0, 0);
    idle_cycles(2);
    // restart clears overflow and count, then reset mid-load after 2 words
    cycle(1, 0, '0, 0, 0, '0, '0, 0);
    cycle(0, 1, 32'hA0A0A0A0, 0, 0, '0, '0, 0);
    cycle(0, 1, 32'hB1B1B1B1, 0, 0, '0, '0, 0);
    @(negedge clk);
    s_start = 0; s_vld = 1; s_data = 32'hC2C2C2C2; s_last = 0; s_dreq = 0; hz = 0;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    m_reset();
    @(posedge clk); #1;
    check_reset("inrst");
    rst_n = 1'b1;
    idle_cycles(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit st;
      case (m_mode[0])
        M_IDLE, M_ERR: st = ($urandom_range(0, 7) == 0);
        M_RUN:         st = ($urandom_range(0, 49) == 0);
        default:       st = ($urandom_range(0, 199) == 0);
      endcase
      cycle(st, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, 8'($urandom), $urandom, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
